// File: rtl/sp_arb_pkg.sv
// Shared types and default sizes for the single-port RAM arbiter.
// No logic; compile-time only.
// Not applicable: holds no datapath.
package sp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;

endpackage

// File: rtl/sp_ram_arbiter_rr_pick.sv
// Round-robin picker: first set request bit after 'last', wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import sp_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [IDW-1:0]     win,
    output logic               any
);

    int idx;

    // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[IDW'(idx)]) begin
                win = IDW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port registered-read RAM among NUM_REQ requesters, round-robin.
// Latency: gnt and RAM strobes one edge after req; read data two edges after gnt.
// Backpressure: requester holds its command until gnt; one access in flight, others wait.
module sp_ram_arbiter
    import sp_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  rvalid,
    output logic [DW-1:0]         rdata,
    output logic [IDW-1:0]        rid,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_wdata,
    input  logic [DW-1:0]         ram_rdata
);

    state_t               state, state_nxt;
    logic [IDW-1:0]       last_q, last_nxt;
    logic [IDW-1:0]       rid_q, rid_q_nxt;
    logic [IDW-1:0]       win;
    logic                 any;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic                 rvalid_nxt;
    logic [DW-1:0]        rdata_nxt;
    logic [IDW-1:0]       rid_nxt;
    logic                 ram_cs_nxt, ram_we_nxt, ram_oe_nxt;
    logic [AW-1:0]        ram_addr_nxt;
    logic [DW-1:0]        ram_wdata_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    // Next-state and next-output decode; strobes default low so cs is high only in GRANT.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last_q;
        rid_q_nxt     = rid_q;
        gnt_nxt       = '0;
        rvalid_nxt    = 1'b0;
        rdata_nxt     = rdata;
        rid_nxt       = rid;
        ram_cs_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_oe_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        case (state)
            IDLE: begin
                if (any) begin
                    gnt_nxt       = NUM_REQ'(1) << win;
                    last_nxt      = win;
                    ram_cs_nxt    = 1'b1;
                    ram_we_nxt    = req_we[win];
                    ram_oe_nxt    = ~req_we[win];
                    ram_addr_nxt  = req_addr[int'(win)*AW +: AW];
                    ram_wdata_nxt = req_wdata[int'(win)*DW +: DW];
                    state_nxt     = GRANT;
                end else begin
                    ram_addr_nxt  = '0;
                    ram_wdata_nxt = '0;
                end
            end
            GRANT: begin
                // The RAM samples the access on this edge; reads need one more cycle.
                if (ram_we) begin
                    state_nxt = IDLE;
                end else begin
                    rid_q_nxt = last_q;
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                rdata_nxt  = ram_rdata;
                rid_nxt    = rid_q;
                rvalid_nxt = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and arbitration pointer; reset leaves requester 0 highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= IDW'(NUM_REQ - 1);
            rid_q     <= '0;
            gnt       <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rid       <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            last_q    <= last_nxt;
            rid_q     <= rid_q_nxt;
            gnt       <= gnt_nxt;
            rvalid    <= rvalid_nxt;
            rdata     <= rdata_nxt;
            rid       <= rid_nxt;
            ram_cs    <= ram_cs_nxt;
            ram_we    <= ram_we_nxt;
            ram_oe    <= ram_oe_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios then random traffic against a transaction model.
// Outputs are compared every cycle on the falling edge.
// Requesters honour the hold-until-gnt handshake.
module tb_sp_ram_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int M_HOLD = 0;
    localparam int M_DROP = 1;
    localparam int M_RAND = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req, req_we, gnt;
    logic [AW-1:0]     a [NR];
    logic [DW-1:0]     d [NR];
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              rvalid;
    logic [DW-1:0]     rdata;
    logic [IDW-1:0]    rid;
    logic              ram_cs, ram_we, ram_oe;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata = '0;
    logic [DW-1:0]     ram_arr [256] = '{default: '0};

    // Transaction-level reference state.
    logic [DW-1:0]     m_mem [256] = '{default: '0};
    int                m_last, cool, pend, pend_id;
    logic [DW-1:0]     pend_data;
    logic [NR-1:0]     exp_gnt;
    logic              exp_cs, exp_we, exp_oe, exp_rv;
    logic [AW-1:0]     exp_addr;
    logic [DW-1:0]     exp_wdata, exp_rdata;
    int                exp_rid;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                mode;
    int                gq[$];
    int                gc[$];

    assign req_addr  = {a[3], a[2], a[1], a[0]};
    assign req_wdata = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_arr[ram_addr[7:0]] <= ram_wdata;
            else        ram_rdata <= ram_arr[ram_addr[7:0]];
        end
    end

    sp_ram_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rid       (rid),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic int gidx(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_last = NR - 1;
        cool   = 0;
        pend   = 0;
    endtask

    task automatic new_cmd(input int i);
        req_we[i] = 1'($urandom_range(1, 0));
        a[i]      = 32'($urandom_range(15, 0));
        d[i]      = $urandom;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge, then drive.
    task automatic tick();
        int w;
        @(posedge clk);
        exp_gnt = '0;
        exp_cs  = 1'b0;
        exp_we  = 1'b0;
        exp_oe  = 1'b0;
        exp_rv  = 1'b0;
        if (!rst_n) begin
            m_reset();
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    exp_rv    = 1'b1;
                    exp_rdata = pend_data;
                    exp_rid   = pend_id;
                end
            end
            if (cool > 0) begin
                cool--;
            end else begin
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
                end
                if (w >= 0) begin
                    exp_gnt   = 4'(1 << w);
                    exp_cs    = 1'b1;
                    exp_we    = req_we[w];
                    exp_oe    = !req_we[w];
                    exp_addr  = a[w];
                    exp_wdata = d[w];
                    m_last    = w;
                    if (req_we[w]) begin
                        m_mem[a[w][7:0]] = d[w];
                        cool = 1;
                    end else begin
                        pend      = 2;
                        pend_data = m_mem[a[w][7:0]];
                        pend_id   = w;
                        cool      = 2;
                    end
                end
            end
        end
        @(negedge clk);
        cyc++;
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("ram_cs", 64'(ram_cs), 64'(exp_cs));
        chk("ram_we", 64'(ram_we), 64'(exp_we));
        chk("ram_oe", 64'(ram_oe), 64'(exp_oe));
        chk("rvalid", 64'(rvalid), 64'(exp_rv));
        if (exp_cs) begin
            chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
            chk("ram_wdata", 64'(ram_wdata), 64'(exp_wdata));
        end
        if (exp_rv) begin
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            chk("rid", 64'(rid), 64'(exp_rid));
        end
        for (int i = 0; i < NR; i++) begin
            if (mode == M_DROP) begin
                if (exp_gnt[i]) req[i] = 1'b0;
            end else if (mode == M_RAND) begin
                if (exp_gnt[i]) begin
                    if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                    else new_cmd(i);
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    new_cmd(i);
                end
            end
        end
    endtask

    initial begin
        int ord3 [5];
        int ord4 [4];
        ord3 = '{0, 1, 2, 3, 0};
        ord4 = '{2, 0, 2, 0};
        rst_n  = 1'b0;
        req    = '0;
        req_we = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        mode = M_DROP;
        m_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state, then idle with no requests.
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_ram_cs", 64'(ram_cs), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        repeat (10) tick();

        // Requester 0 writes then reads back.
        req[0] = 1'b1; req_we[0] = 1'b1; a[0] = 32'h10; d[0] = 32'hDEADBEEF;
        tick();
        chk("wr_gnt", 64'(gnt), 64'b0001);
        chk("wr_cs", 64'(ram_cs), 64'd1);
        chk("wr_we", 64'(ram_we), 64'd1);
        chk("wr_addr", 64'(ram_addr), 64'h10);
        tick();
        tick();
        req[0] = 1'b1; req_we[0] = 1'b0;
        tick();
        chk("rd_gnt", 64'(gnt), 64'b0001);
        chk("rd_oe", 64'(ram_oe), 64'd1);
        tick();
        chk("rd_gap_rvalid", 64'(rvalid), 64'd0);
        tick();
        chk("rd_rvalid", 64'(rvalid), 64'd1);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("rd_rid", 64'(rid), 64'd0);
        tick();
        chk("rd_rvalid_pulse", 64'(rvalid), 64'd0);

        // All four hold write requests from a fresh pointer.
        rst_n = 1'b0;
        m_reset();
        tick();
        rst_n = 1'b1;
        mode = M_HOLD;
        req = 4'b1111; req_we = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            a[i] = 32'h80 + 32'(i);
            d[i] = 32'hA000 + 32'(i);
        end
        gq.delete(); gc.delete();
        repeat (10) begin
            tick();
            if (gnt != '0) begin gq.push_back(gidx(gnt)); gc.push_back(cyc); end
        end
        chk("rr4_count", 64'(gq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk("rr4_order", 64'(gq[i]), 64'(ord3[i]));
            if (i > 0 && i < gc.size()) chk("rr4_spacing", 64'(gc[i] - gc[i-1]), 64'd2);
        end

        // Two alternating requesters after requester 0 was last served.
        req = 4'b0101;
        gq.delete();
        repeat (8) begin
            tick();
            if (gnt != '0) gq.push_back(gidx(gnt));
        end
        chk("rr2_count", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("rr2_order", 64'(gq[i]), 64'(ord4[i]));
        end
        mode = M_DROP;
        req = '0;
        tick();
        tick();

        // Read by 3 completes before a write by 1 raised during the access.
        req[3] = 1'b1; req_we[3] = 1'b1; a[3] = 32'h20; d[3] = 32'h55;
        tick();
        tick();
        req[3] = 1'b1; req_we[3] = 1'b0;
        tick();
        chk("r3_gnt", 64'(gnt), 64'b1000);
        req[1] = 1'b1; req_we[1] = 1'b1; a[1] = 32'h30; d[1] = 32'h1234;
        tick();
        chk("r3_ignore_grant", 64'(gnt), 64'd0);
        tick();
        chk("r3_rvalid", 64'(rvalid), 64'd1);
        chk("r3_rid", 64'(rid), 64'd3);
        chk("r3_rdata", 64'(rdata), 64'h55);
        chk("r3_ignore_rdwait", 64'(gnt), 64'd0);
        tick();
        chk("w1_gnt", 64'(gnt), 64'b0010);
        tick();

        // Reset while a read is waiting for data.
        req[0] = 1'b1; req_we[0] = 1'b0; a[0] = 32'h10;
        tick();
        chk("mr_gnt", 64'(gnt), 64'b0001);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_cs_now", 64'(ram_cs), 64'd0);
        chk("mr_rvalid_now", 64'(rvalid), 64'd0);
        chk("mr_gnt_now", 64'(gnt), 64'd0);
        m_reset();
        tick();
        chk("mr_rvalid_held", 64'(rvalid), 64'd0);
        tick();
        rst_n = 1'b1;
        req = 4'b0011; req_we = 4'b0011;
        a[0] = 32'h40; d[0] = 32'hA0;
        a[1] = 32'h44; d[1] = 32'hA1;
        tick();
        chk("mr_first", 64'(gnt), 64'b0001);
        tick();
        tick();
        chk("mr_second", 64'(gnt), 64'b0010);
        tick();

        // Random traffic against the model.
        mode = M_RAND;
        repeat (600) tick();
        mode = M_DROP;
        req = '0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
